// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory subsystem.
package cpu_mem_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] MMIO_ADDR_DFLT = 16'hFFFF;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cpu_mem_subsystem_sync_ram_1r1w.sv
// Single-write, single-registered-read RAM; read-first on address collision.
module sync_ram_1r1w #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register reset only; the array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/cpu_mem_subsystem.sv
// Memory-side responder: loader FSM fills imem while the CPU is held in reset,
// then serves fetches, data loads/stores and one memory-mapped output register.
module cpu_mem_subsystem
  import cpu_mem_pkg::*;
#(
  parameter int                IMEM_AW   = 8,
  parameter int                DMEM_AW   = 8,
  parameter logic [WORD_W-1:0] MMIO_ADDR = MMIO_ADDR_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_err,
  output logic              cpu_rst_n,
  input  logic [WORD_W-1:0] instr_addr,
  output logic [WORD_W-1:0] instr,
  input  logic [WORD_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_wdata,
  input  logic              mem_wr_en,
  output logic [WORD_W-1:0] data_rdata,
  output logic [WORD_W-1:0] io_out
);

  localparam logic [IMEM_AW-1:0] PTR_MAX = {IMEM_AW{1'b1}};

  state_t               state_reg, state_next;
  logic [IMEM_AW-1:0]   ptr_reg, ptr_next;
  logic                 err_reg, err_next;
  logic                 cpu_rst_n_reg;
  logic [WORD_W-1:0]    io_out_reg;
  logic [WORD_W-1:0]    io_rd_reg;
  logic                 rd_mmio_reg;
  logic                 fetch_ok_reg;
  logic [WORD_W-1:0]    imem_rdata;
  logic [WORD_W-1:0]    dmem_rdata;
  logic                 beat;
  logic                 in_run;
  logic                 addr_is_mmio;
  logic                 dmem_we;
  logic                 unused_instr_hi;
  logic                 unused_data_hi;

  assign in_run       = (state_reg == RUN);
  assign beat         = ld_valid && !in_run;
  assign addr_is_mmio = (data_addr == MMIO_ADDR);
  assign dmem_we      = in_run && mem_wr_en && !addr_is_mmio;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LOAD;
      ptr_reg       <= '0;
      err_reg       <= 1'b0;
      cpu_rst_n_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      err_reg       <= err_next;
      cpu_rst_n_reg <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    err_next   = err_reg;
    case (state_reg)
      LOAD: begin
        if (beat) begin
          ptr_next = ptr_reg + 1'b1;
          if (ld_last) begin
            state_next = RUN;
          end else if (ptr_reg == PTR_MAX) begin
            // Image filled imem without a terminating word.
            state_next = RUN;
            err_next   = 1'b1;
          end
        end
      end
      RUN: begin
        if (ld_start) begin
          state_next = LOAD;
          ptr_next   = '0;
          err_next   = 1'b0;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // The MMIO read returns the register value seen before any same-cycle store.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_out_reg   <= '0;
      io_rd_reg    <= '0;
      rd_mmio_reg  <= 1'b0;
      fetch_ok_reg <= 1'b0;
    end else begin
      if (in_run && mem_wr_en && addr_is_mmio) begin
        io_out_reg <= data_wdata;
      end
      io_rd_reg    <= io_out_reg;
      rd_mmio_reg  <= addr_is_mmio;
      fetch_ok_reg <= in_run;
    end
  end

  sync_ram_1r1w #(.AW(IMEM_AW), .DW(WORD_W)) imem (
    .clk   (clk),
    .rst   (rst),
    .we    (beat),
    .waddr (ptr_reg),
    .wdata (ld_data),
    .raddr (instr_addr[IMEM_AW-1:0]),
    .rdata (imem_rdata)
  );

  sync_ram_1r1w #(.AW(DMEM_AW), .DW(WORD_W)) dmem (
    .clk   (clk),
    .rst   (rst),
    .we    (dmem_we),
    .waddr (data_addr[DMEM_AW-1:0]),
    .wdata (data_wdata),
    .raddr (data_addr[DMEM_AW-1:0]),
    .rdata (dmem_rdata)
  );

  assign unused_instr_hi = &{1'b0, instr_addr[WORD_W-1:IMEM_AW]};
  assign unused_data_hi  = &{1'b0, data_addr[WORD_W-1:DMEM_AW]};

  assign ld_ready   = !in_run;
  assign ld_err     = err_reg;
  assign cpu_rst_n  = cpu_rst_n_reg;
  assign instr      = fetch_ok_reg ? imem_rdata : '0;
  assign data_rdata = rd_mmio_reg ? io_rd_reg : dmem_rdata;
  assign io_out     = io_out_reg;

endmodule

// File: tb/tb_cpu_mem_subsystem.sv
// Directed self-checking bench for cpu_mem_subsystem.
module tb_cpu_mem_subsystem;

  logic        clk = 1'b0;
  logic        rst, ld_start, ld_valid, ld_last, mem_wr_en;
  logic [15:0] ld_data, instr_addr, data_addr, data_wdata;
  logic        ld_ready, ld_err, cpu_rst_n;
  logic [15:0] instr, data_rdata, io_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_mem_subsystem #(.IMEM_AW(8), .DMEM_AW(8), .MMIO_ADDR(16'hFFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_err     (ld_err),
    .cpu_rst_n  (cpu_rst_n),
    .instr_addr (instr_addr),
    .instr      (instr),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .mem_wr_en  (mem_wr_en),
    .data_rdata (data_rdata),
    .io_out     (io_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ld_ready"}, ld_ready, 1'b1);
    chk1({tag, "_ld_err"}, ld_err, 1'b0);
    chk1({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
    chk({tag, "_instr"}, instr, 16'h0000);
    chk({tag, "_data_rdata"}, data_rdata, 16'h0000);
    chk({tag, "_io_out"}, io_out, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; mem_wr_en = 1'b0;
    ld_data = '0; instr_addr = '0; data_addr = '0; data_wdata = '0;
    tick(); tick();
    chk_reset_outputs("reset");
    $display("step reset: ld_ready=%b cpu_rst_n=%b", ld_ready, cpu_rst_n);
    rst = 1'b0;

    // 1: three-word image
    ld_valid = 1'b1; ld_data = 16'h1111; tick();
    ld_data = 16'h2222; tick();
    chk1("t1_held_in_reset", cpu_rst_n, 1'b0);
    ld_data = 16'h3333; ld_last = 1'b1; tick();
    chk1("t1_cpu_released", cpu_rst_n, 1'b1);
    chk1("t1_ld_ready_low", ld_ready, 1'b0);
    ld_valid = 1'b0; ld_last = 1'b0;
    instr_addr = 16'h0001; tick();
    chk("t1_fetch1", instr, 16'h2222);
    instr_addr = 16'h0102; tick();
    chk("t1_fetch_wrap", instr, 16'h3333);
    $display("step load3: instr=%h", instr);

    // 2: store then read, with alias
    mem_wr_en = 1'b1; data_addr = 16'h0005; data_wdata = 16'hBEEF; tick();
    mem_wr_en = 1'b0; tick();
    chk("t2_read5", data_rdata, 16'hBEEF);
    data_addr = 16'h0105; tick();
    chk("t2_alias", data_rdata, 16'hBEEF);
    $display("step store_read: data_rdata=%h", data_rdata);

    // 3: read-first collision
    mem_wr_en = 1'b1; data_addr = 16'h0007; data_wdata = 16'hAAAA; tick();
    data_wdata = 16'h1234; tick();
    chk("t3_read_first", data_rdata, 16'hAAAA);
    mem_wr_en = 1'b0; tick();
    chk("t3_new_data", data_rdata, 16'h1234);
    $display("step read_first: data_rdata=%h", data_rdata);

    // 4: MMIO register
    mem_wr_en = 1'b1; data_addr = 16'h00FF; data_wdata = 16'h5A5A; tick();
    data_addr = 16'hFFFF; data_wdata = 16'h00F0; tick();
    chk("t4_io_out", io_out, 16'h00F0);
    mem_wr_en = 1'b0; tick();
    chk("t4_mmio_read", data_rdata, 16'h00F0);
    data_addr = 16'h00FF; tick();
    chk("t4_dmem_ff_kept", data_rdata, 16'h5A5A);
    $display("step mmio: io_out=%h", io_out);

    // 5: overflow image, then reload request
    ld_start = 1'b1; tick();
    ld_start = 1'b0;
    chk1("t5_start_cpu_rst_n", cpu_rst_n, 1'b0);
    chk1("t5_start_ld_ready", ld_ready, 1'b1);
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 16'hC000 ^ 16'(i); tick();
    end
    ld_valid = 1'b0;
    chk1("t5_overflow_err", ld_err, 1'b1);
    chk1("t5_overflow_run", ld_ready, 1'b0);
    chk1("t5_overflow_cpu_rst_n", cpu_rst_n, 1'b1);
    instr_addr = 16'h00FF; tick();
    chk("t5_fetch_last", instr, 16'hC0FF);
    ld_start = 1'b1; tick();
    ld_start = 1'b0;
    chk1("t5_restart_err_clear", ld_err, 1'b0);
    chk1("t5_restart_cpu_rst_n", cpu_rst_n, 1'b0);
    chk1("t5_restart_ld_ready", ld_ready, 1'b1);
    tick();
    chk("t5_instr_zero_in_load", instr, 16'h0000);
    $display("step overflow: ld_err cleared, ld_ready=%b", ld_ready);

    // 6: stores ignored in LOAD, reset mid-load
    ld_valid = 1'b1; ld_data = 16'h7777;
    mem_wr_en = 1'b1; data_addr = 16'h0005; data_wdata = 16'hDEAD; tick();
    ld_data = 16'h8888; data_addr = 16'hFFFF; data_wdata = 16'h1111; tick();
    chk("t6_io_out_unchanged", io_out, 16'h00F0);
    rst = 1'b1; ld_valid = 1'b0; mem_wr_en = 1'b0; data_addr = 16'h0000; tick();
    chk_reset_outputs("t6_reset");
    rst = 1'b0;
    ld_valid = 1'b1; ld_data = 16'hA001; tick();
    ld_data = 16'hA002; tick();
    ld_data = 16'hA003; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    instr_addr = 16'h0000; data_addr = 16'h0005; tick();
    chk("t6_restart_at_zero", instr, 16'hA001);
    chk("t6_dmem_unchanged", data_rdata, 16'hBEEF);
    $display("step reset_midload: instr=%h data_rdata=%h", instr, data_rdata);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
